// File: rtl/window_correlator_pkg.sv
// Shared definitions for the window correlator: burst FSM encoding and log2 helper.
package window_correlator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BURST   = 2'b01,
    ST_DISCARD = 2'b10
  } state_t;

  // Ceiling log2, used to size index ports from the window length.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/window_correlator_coef_ram.sv
// Simple dual-port coefficient RAM with registered read, block-RAM inferable.
module coef_ram
  import window_correlator_pkg::*;
#(
  parameter int PAR_DEPTH      = 128,
  parameter int PAR_WIDTH      = 16,
  parameter int PAR_ADDR_WIDTH = 7
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [PAR_ADDR_WIDTH-1:0] i_waddr,
  input  logic [PAR_WIDTH-1:0]      i_wdata,
  input  logic                      i_re,
  input  logic [PAR_ADDR_WIDTH-1:0] i_raddr,
  output logic [PAR_WIDTH-1:0]      o_rdata
);

  logic [PAR_WIDTH-1:0] mem_q [PAR_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem_q[i_raddr];
  end

endmodule

// File: rtl/window_correlator.sv
// Reduces each indexed sample burst to one coefficient-weighted sum, rejecting malformed bursts.
module window_correlator
  import window_correlator_pkg::*;
#(
  parameter int  PAR_DATA_WIDTH = 16,
  parameter int  PAR_COEF_WIDTH = 16,
  parameter int  PAR_WIN_LEN    = 128,
  localparam int PAR_IDX_WIDTH  = log2(PAR_WIN_LEN),
  localparam int PAR_ACC_WIDTH  = PAR_DATA_WIDTH + PAR_COEF_WIDTH + PAR_IDX_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      s_axis_tvalid,
  input  logic [PAR_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PAR_IDX_WIDTH-1:0]  s_axis_tuser,
  input  logic                      s_axis_tlast,
  input  logic                      i_coef_we,
  input  logic [PAR_IDX_WIDTH-1:0]  i_coef_addr,
  input  logic [PAR_COEF_WIDTH-1:0] i_coef_data,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [PAR_ACC_WIDTH-1:0]  m_axis_tdata,
  output logic                      o_frame_err,
  output logic                      o_overflow,
  output logic                      o_cfg_err
);

  localparam int PROD_W = PAR_DATA_WIDTH + PAR_COEF_WIDTH;
  localparam logic [PAR_IDX_WIDTH-1:0] LAST_IDX = PAR_IDX_WIDTH'(PAR_WIN_LEN - 1);

  state_t                     state_q, state_d;
  logic [PAR_IDX_WIDTH-1:0]   exp_q, exp_d;
  logic                       burst_bad;
  logic                       take, take_first, take_commit, frame_err_d;

  logic                       s1_valid_q, s1_first_q, s1_commit_q;
  logic signed [PAR_DATA_WIDTH-1:0] s1_data_q;
  logic [PAR_COEF_WIDTH-1:0]  coef_rd;
  logic                       s2_valid_q, s2_first_q, s2_commit_q;
  logic signed [PROD_W-1:0]   prod, s2_prod_q;
  logic [PAR_ACC_WIDTH-1:0]   prod_ext, acc_q, acc_d;

  logic                       cfg_ok, coef_we, cfg_err_d;
  logic                       commit;
  logic                       m_tvalid_q, m_tvalid_d, ovf_d;
  logic [PAR_ACC_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                       frame_err_q, ovf_q, cfg_err_q;

  // A burst sample is bad if out of order, or if tlast disagrees with being the final index.
  always_comb begin
    burst_bad = (s_axis_tuser != exp_q) || (s_axis_tlast != (s_axis_tuser == LAST_IDX));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    unique case (state_q)
      ST_IDLE: if (s_axis_tvalid) begin
        if (s_axis_tuser == '0 && !s_axis_tlast) begin
          state_d = ST_BURST;
          exp_d   = PAR_IDX_WIDTH'(1);
        end else if (!s_axis_tlast) begin
          state_d = ST_DISCARD;
        end
      end
      ST_BURST: if (s_axis_tvalid) begin
        if (burst_bad)         state_d = s_axis_tlast ? ST_IDLE : ST_DISCARD;
        else if (s_axis_tlast) state_d = ST_IDLE;
        else                   exp_d   = exp_q + PAR_IDX_WIDTH'(1);
      end
      ST_DISCARD: if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    take        = 1'b0;
    take_first  = 1'b0;
    take_commit = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (s_axis_tvalid) begin
        if (s_axis_tuser == '0 && !s_axis_tlast) begin
          take       = 1'b1;
          take_first = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      ST_BURST: if (s_axis_tvalid) begin
        if (burst_bad) begin
          frame_err_d = 1'b1;
        end else begin
          take        = 1'b1;
          take_commit = s_axis_tlast;
        end
      end
      default: ;
    endcase
  end

  // The input stage counts as occupied so a write can never race a burst's first read.
  assign cfg_ok    = (state_q == ST_IDLE) && !s_axis_tvalid && !s1_valid_q && !s2_valid_q;
  assign coef_we   = i_coef_we && cfg_ok;
  assign cfg_err_d = i_coef_we && !cfg_ok;

  coef_ram #(
    .PAR_DEPTH      (PAR_WIN_LEN),
    .PAR_WIDTH      (PAR_COEF_WIDTH),
    .PAR_ADDR_WIDTH (PAR_IDX_WIDTH)
  ) u_coef_ram (
    .i_clk   (i_clk),
    .i_we    (coef_we),
    .i_waddr (i_coef_addr),
    .i_wdata (i_coef_data),
    .i_re    (take),
    .i_raddr (s_axis_tuser),
    .o_rdata (coef_rd)
  );

  assign prod     = s1_data_q * $signed(coef_rd);
  assign prod_ext = {{PAR_IDX_WIDTH{s2_prod_q[PROD_W-1]}}, s2_prod_q};
  assign acc_d    = s2_first_q ? prod_ext : acc_q + prod_ext;
  assign commit   = s2_valid_q && s2_commit_q;

  always_comb begin
    m_tvalid_d = m_tvalid_q && !m_axis_tready;
    m_tdata_d  = m_tdata_q;
    ovf_d      = 1'b0;
    if (commit) begin
      if (!m_tvalid_q || m_axis_tready) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = acc_d;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_commit_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_commit_q <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= take;
      s1_first_q  <= take_first;
      s1_commit_q <= take_commit;
      s2_valid_q  <= s1_valid_q;
      s2_first_q  <= s1_first_q;
      s2_commit_q <= s1_commit_q;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (take)       s1_data_q <= $signed(s_axis_tdata);
    if (s1_valid_q) s2_prod_q <= prod;
    if (s2_valid_q) acc_q     <= acc_d;
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign o_frame_err   = frame_err_q;
  assign o_overflow    = ovf_q;
  assign o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_window_correlator.sv
// Directed-sequence bench with random data, checked against an arithmetic reference model.
module tb_window_correlator;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int WL = 4;
  localparam int IW = 2;
  localparam int AW = DW + CW + IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_tvalid, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [IW-1:0] s_tuser;
  logic          coef_we;
  logic [IW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          m_tvalid, m_tready;
  logic [AW-1:0] m_tdata;
  logic          frame_err, overflow, cfg_err;

  always #5 clk = ~clk;

  window_correlator #(
    .PAR_DATA_WIDTH (DW),
    .PAR_COEF_WIDTH (CW),
    .PAR_WIN_LEN    (WL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .i_coef_we     (coef_we),
    .i_coef_addr   (coef_addr),
    .i_coef_data   (coef_data),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .o_frame_err   (frame_err),
    .o_overflow    (overflow),
    .o_cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int cfg_cnt  = 0;

  longint                coef_m [WL];
  logic signed [DW-1:0]  bd [WL];
  longint                exp_q [$];
  longint                rx_q [$];
  int                    rx_cyc [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      rx_q.push_back(longint'($signed(m_tdata)));
      rx_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (overflow)  ovf_cnt++;
    if (cfg_err)   cfg_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [DW-1:0] d, input int idx, input bit last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = IW'(idx);
    s_tlast  = last;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < WL; i++) s += longint'(bd[i]) * coef_m[i];
    return s;
  endfunction

  task automatic send_burst(input bit expect_result);
    if (expect_result) exp_q.push_back(model_sum());
    for (int i = 0; i < WL; i++) send(bd[i], i, i == WL - 1);
  endtask

  task automatic write_coef(input int a, input logic signed [CW-1:0] v, input bit honoured);
    coef_we   = 1'b1;
    coef_addr = IW'(a);
    coef_data = v;
    tick();
    coef_we = 1'b0;
    if (honoured) coef_m[a] = longint'(v);
  endtask

  task automatic rand_burst_data();
    for (int i = 0; i < WL; i++) bd[i] = DW'($urandom);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    repeat (6) tick();
    while (rx_q.size() < exp_q.size() && k < 40) begin
      tick();
      k++;
    end
    chk({tag, " result count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0) chk({tag, " sum"}, rx_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  initial begin
    int k;
    int c0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tuser = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; m_tready = 1'b1;
    repeat (3) tick();
    chk("reset tvalid", m_tvalid, 0);
    chk("reset tdata", $signed(m_tdata), 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overflow", overflow, 0);
    chk("reset cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();

    // Basic burst with exact latency
    for (int i = 0; i < WL; i++) write_coef(i, CW'(i + 1), 1'b1);
    bd[0] = 10; bd[1] = 20; bd[2] = 30; bd[3] = 40;
    send_burst(1'b1);
    chk("basic tvalid t+1", m_tvalid, 0);
    tick();
    chk("basic tvalid t+2", m_tvalid, 0);
    tick();
    chk("basic tvalid t+3", m_tvalid, 1);
    chk("basic tdata", $signed(m_tdata), 300);
    drain("basic");
    chk("basic no cfg_err", cfg_cnt, 0);
    chk("basic no frame_err", ferr_cnt, 0);

    // Negative values, two bursts back to back
    write_coef(0, -16'sd1, 1'b1);
    write_coef(1, 16'sd2, 1'b1);
    write_coef(2, -16'sd3, 1'b1);
    write_coef(3, 16'sd4, 1'b1);
    bd[0] = -5; bd[1] = 5; bd[2] = -5; bd[3] = 5;
    send_burst(1'b1);
    send_burst(1'b1);
    k = 0;
    while (rx_q.size() < 2 && k < 20) begin tick(); k++; end
    chk("b2b first sum", rx_q.size() > 0 ? rx_q[0] : -1, 50);
    chk("b2b spacing", rx_cyc.size() > 1 ? rx_cyc[1] - rx_cyc[0] : -1, WL);
    drain("b2b");

    // Malformed bursts
    ferr_cnt = 0;
    send(16'sd7, 0, 1'b1);
    chk("idx0 tlast frame_err t+1", frame_err, 1);
    send(16'sd1, 0, 1'b0);
    send(16'sd2, 2, 1'b0);
    chk("skip frame_err t+1", frame_err, 1);
    send(16'sd3, 3, 1'b1);
    chk("skip discard end no err", frame_err, 0);
    rand_burst_data();
    send_burst(1'b1);
    drain("after skip");
    chk("frame_err pulses", ferr_cnt, 2);

    // Backpressure: second commit dropped while first is held
    ovf_cnt  = 0;
    m_tready = 1'b0;
    rand_burst_data();
    send_burst(1'b1);
    rand_burst_data();
    send_burst(1'b0);
    repeat (5) tick();
    chk("bp tvalid held", m_tvalid, 1);
    chk("bp tdata held", $signed(m_tdata), exp_q.size() > 0 ? exp_q[0] : -1);
    chk("bp overflow pulses", ovf_cnt, 1);
    m_tready = 1'b1;
    drain("bp");
    chk("bp tvalid drops", m_tvalid, 0);

    // Coefficient write during a burst is ignored
    cfg_cnt = 0;
    rand_burst_data();
    exp_q.push_back(model_sum());
    send(bd[0], 0, 1'b0);
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd999;
    send(bd[1], 1, 1'b0);
    coef_we = 1'b0;
    chk("mid-burst cfg_err w+1", cfg_err, 1);
    for (int i = 2; i < WL; i++) send(bd[i], i, i == WL - 1);
    drain("mid-burst write");
    chk("cfg_err pulses", cfg_cnt, 1);

    // Reset in the middle of a burst
    rand_burst_data();
    send(bd[0], 0, 1'b0);
    send(bd[1], 1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("mid reset tvalid", m_tvalid, 0);
    chk("mid reset tdata", $signed(m_tdata), 0);
    rst_n = 1'b1;
    tick();
    rand_burst_data();
    send_burst(1'b1);
    drain("post reset");

    // Random rounds
    for (int r = 0; r < 12; r++) begin
      if (r % 3 == 0) for (int i = 0; i < WL; i++) write_coef(i, CW'($urandom), 1'b1);
      c0 = int'($urandom_range(1, 3));
      for (int b = 0; b < c0; b++) begin
        rand_burst_data();
        send_burst(1'b1);
      end
      repeat ($urandom_range(0, 2)) tick();
      drain("random");
    end
    chk("random no overflow", ovf_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
